alu_adder_unit: RTL and testbench

ALU_ADDER_UNIT -- requirements
Module: alu_adder_unit

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_adder_unit_adder.sv | 16 +
 rtl/alu_adder_unit.sv | 94 +++++++++
 tb/tb_alu_adder_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU/adder unit.
//   alu_op_t        - 3-bit ALU operation encodings carried on alu_sel
//   PC_STEP_DEFAULT - default increment for the sequential program counter
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    localparam int PC_STEP_DEFAULT = 32'd4;

endpackage

// File: rtl/alu_adder_unit_adder.sv
// adder: plain WIDTH-bit adder, result wraps modulo 2^WIDTH.
// Ports:
//   a   - addend
//   b   - addend
//   out - a + b (carry discarded)
module adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out
);

    assign out = a + b;

endmodule

// File: rtl/alu_adder_unit.sv
// alu_adder_unit: execute-stage ALU with a one-cycle result register plus
// two combinational program-counter adders.
// Ports:
//   clk         - rising-edge clock for the result register
//   rst         - asynchronous active-low reset (alu_out=0, zero=1)
//   en          - result-register enable, 0 stalls the register
//   a, b        - ALU operands
//   alu_sel     - ALU operation select (alu_op_t encoding)
//   pc          - current program counter
//   imm         - sign-extended branch offset (in halfwords)
//   alu_out     - registered ALU result
//   zero        - registered flag, 1 when alu_out is 0
//   pc_next_seq - pc + PC_STEP (combinational)
//   pc_branch   - pc + (imm << 1) (combinational)
module alu_adder_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int PC_STEP = alu_pkg::PC_STEP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic [WIDTH-1:0] pc_branch
);

    // Shifts use only the low log2(WIDTH) bits of b; the rest are ignored.
    localparam int SHW = $clog2(WIDTH);

    alu_op_t          op_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] alu_result_s;
    logic [WIDTH-1:0] alu_out_r;
    logic             zero_r;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] branch_off_s;

    assign op_s         = alu_op_t'(alu_sel);
    assign shamt_s      = b[SHW-1:0];
    assign step_s       = WIDTH'(PC_STEP);
    // Branch offsets are in halfword units, hence the single-bit scale.
    assign branch_off_s = imm << 1;

    // ALU core: decode the operation and compute the next result.
    always_comb begin
        alu_result_s = {WIDTH{1'b0}};
        case (op_s)
            ALU_ADD: alu_result_s = a + b;
            ALU_SUB: alu_result_s = a - b;
            ALU_AND: alu_result_s = a & b;
            ALU_OR:  alu_result_s = a | b;
            ALU_XOR: alu_result_s = a ^ b;
            ALU_SLL: alu_result_s = a << shamt_s;
            ALU_SRL: alu_result_s = a >> shamt_s;
            ALU_SLT: alu_result_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_result_s = {WIDTH{1'b0}};
        endcase
    end

    // Result register: capture on enabled edges, hold on stall, clear on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_out_r <= {WIDTH{1'b0}};
            zero_r    <= 1'b1;
        end else if (en) begin
            alu_out_r <= alu_result_s;
            zero_r    <= (alu_result_s == {WIDTH{1'b0}});
        end
    end

    assign alu_out = alu_out_r;
    assign zero    = zero_r;

    adder #(.WIDTH(WIDTH)) u_pc_seq_adder (
        .a   (pc),
        .b   (step_s),
        .out (pc_next_seq)
    );

    adder #(.WIDTH(WIDTH)) u_pc_branch_adder (
        .a   (pc),
        .b   (branch_off_s),
        .out (pc_branch)
    );

endmodule

// File: tb/tb_alu_adder_unit.sv
// tb_alu_adder_unit: self-checking bench for alu_adder_unit (WIDTH=64).
module tb_alu_adder_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  alu_sel;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] alu_out;
    logic        zero;
    logic [63:0] pc_next_seq;
    logic [63:0] pc_branch;

    int errors = 0;
    int checks = 0;

    alu_adder_unit #(.WIDTH(64), .PC_STEP(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .a           (a),
        .b           (b),
        .alu_sel     (alu_sel),
        .pc          (pc),
        .imm         (imm),
        .alu_out     (alu_out),
        .zero        (zero),
        .pc_next_seq (pc_next_seq),
        .pc_branch   (pc_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    // Reference ALU written from the operation table with plain arithmetic.
    function automatic logic [63:0] ref_alu(input logic [63:0] x, input logic [63:0] y,
                                            input logic [2:0] s);
        longint sx;
        longint sy;
        int     sh;
        sx = x;
        sy = y;
        sh = int'(y % 64);
        case (s)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x & y;
            3'd3:    return x | y;
            3'd4:    return x ^ y;
            3'd5:    return x << sh;
            3'd6:    return x >> sh;
            3'd7:    return (sx < sy) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Drive one operation, let one edge pass, then check result and flag.
    task automatic op_step(input string tag, input logic [63:0] x, input logic [63:0] y,
                           input logic [2:0] s, input logic [63:0] exp);
        a = x; b = y; alu_sel = s; en = 1'b1;
        @(posedge clk); #1;
        check({tag, "_out"}, alu_out, exp);
        check({tag, "_zero"}, {63'd0, zero}, {63'd0, (exp == 64'd0)});
    endtask

    logic [63:0] exp_out;

    initial begin
        rst = 1'b0; en = 1'b0; a = 64'd0; b = 64'd0; alu_sel = 3'd0;
        pc = 64'd0; imm = 64'd0;

        // Reset held with random activity on every input.
        for (int i = 0; i < 5; i++) begin
            a = rnd64(); b = rnd64(); alu_sel = 3'($urandom_range(7, 0));
            en = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
            check("rst_hold_out", alu_out, 64'd0);
            check("rst_hold_zero", {63'd0, zero}, 64'd1);
        end

        // Release and directed arithmetic.
        rst = 1'b1;
        op_step("add_5_7", 64'd5, 64'd7, 3'b000, 64'd12);
        op_step("sub_5_7", 64'd5, 64'd7, 3'b001, 64'hFFFF_FFFF_FFFF_FFFE);
        op_step("sub_9_9", 64'd9, 64'd9, 3'b001, 64'd0);
        op_step("and", 64'hF0F0, 64'h0FF0, 3'b010, 64'h00F0);
        op_step("or", 64'hF0F0, 64'h0FF0, 3'b011, 64'hFFF0);
        op_step("xor", 64'hF0F0, 64'h0FF0, 3'b100, 64'hFF00);
        op_step("sll_upper_b", 64'd1, 64'h43, 3'b101, 64'd8);
        op_step("srl_63", 64'h8000_0000_0000_0000, 64'd63, 3'b110, 64'd1);
        op_step("slt_m1_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b111, 64'd1);
        op_step("slt_1_m1", 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 64'd0);
        op_step("slt_eq", 64'd77, 64'd77, 3'b111, 64'd0);
        op_step("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'b000, 64'd1);

        // Stall: capture 12, then hold through three cycles of new inputs.
        op_step("stall_load", 64'd5, 64'd7, 3'b000, 64'd12);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 64'd100 + 64'(i); b = 64'd3; alu_sel = 3'($urandom_range(7, 0));
            @(posedge clk); #1;
            check("stall_hold_out", alu_out, 64'd12);
            check("stall_hold_zero", {63'd0, zero}, 64'd0);
        end
        op_step("stall_resume", 64'd20, 64'd22, 3'b000, 64'd42);

        // Asynchronous reset mid-cycle, well before the next rising edge.
        #2 rst = 1'b0;
        #1;
        check("async_rst_out", alu_out, 64'd0);
        check("async_rst_zero", {63'd0, zero}, 64'd1);
        en = 1'b1; a = 64'd3; b = 64'd4; alu_sel = 3'b000;
        @(posedge clk); #1;
        check("async_rst_hold", alu_out, 64'd0);
        rst = 1'b1;

        // PC adders, directed then random.
        pc = 64'h100; imm = 64'd8; #1;
        check("pc_seq_100", pc_next_seq, 64'h104);
        check("pc_br_p8", pc_branch, 64'h110);
        imm = 64'hFFFF_FFFF_FFFF_FFFC; #1;
        check("pc_br_m4", pc_branch, 64'hF8);
        pc = 64'hFFFF_FFFF_FFFF_FFFF; #1;
        check("pc_seq_wrap", pc_next_seq, 64'd3);
        for (int i = 0; i < 8; i++) begin
            pc = rnd64(); imm = rnd64(); #1;
            check("pc_seq_rand", pc_next_seq, pc + 64'd4);
            check("pc_br_rand", pc_branch, pc + imm * 64'd2);
        end

        // Random operations with random stalls against the reference model.
        exp_out = alu_out;
        for (int i = 0; i < 200; i++) begin
            a = rnd64();
            b = ($urandom_range(7, 0) == 0) ? a : rnd64();
            if ($urandom_range(3, 0) == 0) b = {56'd0, 8'($urandom())};
            alu_sel = 3'($urandom_range(7, 0));
            en = ($urandom_range(3, 0) != 0);
            if (en) exp_out = ref_alu(a, b, alu_sel);
            @(posedge clk); #1;
            check("rand_out", alu_out, exp_out);
            check("rand_zero", {63'd0, zero}, {63'd0, (exp_out == 64'd0)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
